// File: rtl/jk_chk_pkg.sv
// Shared types and JK input codes for the JK flip-flop checker and related JK logic.
package jk_chk_pkg;

  typedef enum logic [1:0] {
    UNSYNC = 2'd0,
    TRACK  = 2'd1,
    HALT   = 2'd2
  } state_t;

  localparam logic [1:0] HOLD   = 2'b00;
  localparam logic [1:0] RESET  = 2'b01;
  localparam logic [1:0] SET    = 2'b10;
  localparam logic [1:0] TOGGLE = 2'b11;

endpackage

// File: rtl/jk_model.sv
// Combinational JK next-state function f(m,j,k); reusable by any JK-based logic.
module jk_model
  import jk_chk_pkg::*;
(
  input  logic m_i,
  input  logic j_i,
  input  logic k_i,
  output logic q_o
);

  always_comb begin
    q_o = m_i;
    case ({j_i, k_i})
      HOLD:    q_o = m_i;
      RESET:   q_o = 1'b0;
      SET:     q_o = 1'b1;
      TOGGLE:  q_o = ~m_i;
      default: q_o = m_i;
    endcase
  end

endmodule

// File: rtl/jk_ff_checker.sv
// In-circuit checker for a positive-edge JK flip-flop: predicts Q and flags disagreements.
// Define JK_CHK_STICKY_EN to halt on the first failed compare instead of realigning.
module jk_ff_checker
  import jk_chk_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             j,
  input  logic             k,
  input  logic             q,
  input  logic             q_bar,
  output logic             synced,
  output logic             mismatch,
  output logic             fail,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] chk_count
);

`ifdef JK_CHK_STICKY_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t           state_q;
  logic             model_q;
  logic             synced_q;
  logic             mismatch_q;
  logic             fail_q;
  logic [CNT_W-1:0] err_q;
  logic [CNT_W-1:0] chk_q;

  logic pred_q;
  logic realign_q;
  logic model_d;
  logic cmp_fail;

  jk_model u_pred (
    .m_i (model_q),
    .j_i (j),
    .k_i (k),
    .q_o (pred_q)
  );

  // Realign from the observed q so one upset is counted once rather than cascading.
  jk_model u_realign (
    .m_i (q),
    .j_i (j),
    .k_i (k),
    .q_o (realign_q)
  );

  assign cmp_fail = (q != model_q) || (q_bar == q);
  assign model_d  = (cmp_fail && !STICKY) ? realign_q : pred_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= UNSYNC;
      model_q    <= 1'b0;
      synced_q   <= 1'b0;
      mismatch_q <= 1'b0;
      fail_q     <= 1'b0;
      err_q      <= '0;
      chk_q      <= '0;
    end else begin
      mismatch_q <= 1'b0;
      case (state_q)
        UNSYNC: begin
          if (j ^ k) begin
            model_q  <= j;
            synced_q <= 1'b1;
            state_q  <= TRACK;
          end
        end
        TRACK: begin
          chk_q      <= sat_inc(chk_q);
          mismatch_q <= cmp_fail;
          model_q    <= model_d;
          if (cmp_fail) begin
            fail_q <= 1'b1;
            err_q  <= sat_inc(err_q);
            if (STICKY) state_q <= HALT;
          end
        end
        HALT: begin
          state_q <= HALT;
        end
        default: state_q <= UNSYNC;
      endcase
    end
  end

  assign synced    = synced_q;
  assign mismatch  = mismatch_q;
  assign fail      = fail_q;
  assign err_count = err_q;
  assign chk_count = chk_q;

endmodule

// File: tb/tb_jk_ff_checker.sv
// Directed bench for jk_ff_checker: a reference JK flop drives q/q_bar, with injected upsets.
module tb_jk_ff_checker;

`ifdef JK_CHK_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       j = 1'b0, k = 1'b0, q = 1'b0, q_bar = 1'b1;
  logic       synced, mismatch, fail;
  logic [7:0] err_count, chk_count;
  logic       synced2, mismatch2, fail2;
  logic [1:0] err_count2, chk_count2;

  logic ffq = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  jk_ff_checker #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .j(j), .k(k), .q(q), .q_bar(q_bar),
    .synced(synced), .mismatch(mismatch), .fail(fail),
    .err_count(err_count), .chk_count(chk_count)
  );

  jk_ff_checker #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .j(j), .k(k), .q(q), .q_bar(q_bar),
    .synced(synced2), .mismatch(mismatch2), .fail(fail2),
    .err_count(err_count2), .chk_count(chk_count2)
  );

  function automatic logic jk_ref(input logic m, input logic jv, input logic kv);
    if (jv && kv) return ~m;
    if (jv) return 1'b1;
    if (kv) return 1'b0;
    return m;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  // One clock of stimulus: upset flips the reference flop state, qbar_bad drives q_bar equal to q.
  task automatic drive(input logic jv, input logic kv, input logic upset, input logic qbar_bad);
    j = jv;
    k = kv;
    if (upset) ffq = ~ffq;
    q     = ffq;
    q_bar = qbar_bad ? ffq : ~ffq;
    @(posedge clk);
    ffq = jk_ref(ffq, jv, kv);
    #1;
  endtask

  logic [1:0] pat [8] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b10, 2'b01, 2'b11};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    rst = 1'b0;
    check("rst_synced", synced, 0);
    check("rst_mismatch", mismatch, 0);
    check("rst_fail", fail, 0);
    check("rst_err", err_count, 0);
    check("rst_chk", chk_count, 0);

    // No sync on 00 / 11; sync on 01
    drive(0, 0, 0, 0);
    check("unsync00_synced", synced, 0);
    drive(1, 1, 0, 0);
    check("unsync11_chk", chk_count, 0);
    check("unsync11_synced", synced, 0);
    drive(0, 1, 0, 0);
    check("sync_synced", synced, 1);
    check("sync_chk", chk_count, 0);
    drive(0, 0, 0, 0);
    check("first_cmp_chk", chk_count, 1);
    check("first_cmp_err", err_count, 0);
    check("first_cmp_mis", mismatch, 0);

    // Clean sequence, 32 compares
    for (int r = 0; r < 4; r++)
      for (int i = 0; i < 8; i++) drive(pat[i][1], pat[i][0], 0, 0);
    check("clean_chk", chk_count, 33);
    check("clean_err", err_count, 0);
    check("clean_fail", fail, 0);

    // Single state upset where the model predicts 0
    drive(0, 1, 0, 0);
    drive(0, 0, 1, 0);
    check("upset_mis", mismatch, 1);
    check("upset_err", err_count, 1);
    check("upset_fail", fail, 1);
    check("upset_chk", chk_count, 35);
    drive(1, 1, 0, 0);
    check("post_upset_mis", mismatch, 0);
    check("post_upset_chk", chk_count, STICKY ? 35 : 36);
    drive(0, 1, 0, 0);
    check("post_upset2_err", err_count, 1);
    check("post_upset2_chk", chk_count, STICKY ? 35 : 37);
    check("post_upset_synced", synced, 1);

    // q_bar not the complement of q while q is correct
    drive(0, 0, 0, 1);
    check("qbar_mis", mismatch, STICKY ? 0 : 1);
    check("qbar_err", err_count, STICKY ? 1 : 2);
    drive(1, 0, 0, 0);
    check("qbar_after_mis", mismatch, 0);
    check("qbar_after_chk", chk_count, STICKY ? 35 : 39);

    // q and q_bar both wrong in one cycle: counted once
    drive(0, 0, 1, 1);
    check("both_err", err_count, STICKY ? 1 : 3);
    check("both_chk", chk_count, STICKY ? 35 : 40);
    check("both_fail", fail, 1);

    // Saturation on the 2-bit instance
    rst = 1'b1;
    drive(0, 0, 0, 0);
    rst = 1'b0;
    check("rst2_err2", err_count2, 0);
    drive(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, 0);
      drive(0, 0, 0, 0);
    end
    check("sat_err8", err_count, STICKY ? 1 : 5);
    check("sat_chk8", chk_count, STICKY ? 1 : 10);
    check("sat_err2", err_count2, STICKY ? 1 : 3);
    check("sat_chk2", chk_count2, STICKY ? 1 : 3);
    check("sat_fail2", fail2, 1);

    // Mid-stream reset; inputs at the reset edge are ignored
    rst = 1'b1;
    drive(0, 1, 0, 0);
    rst = 1'b0;
    check("mrst_synced", synced, 0);
    check("mrst_fail", fail, 0);
    check("mrst_err", err_count, 0);
    check("mrst_chk", chk_count, 0);
    check("mrst_synced2", synced2, 0);
    check("mrst_err2", err_count2, 0);
    check("mrst_mis2", mismatch2, 0);
    drive(0, 0, 0, 0);
    check("mrst_hold_synced", synced, 0);
    drive(1, 0, 0, 0);
    check("resync_synced", synced, 1);
    drive(1, 1, 0, 0);
    check("resync_chk", chk_count, 1);
    check("resync_err", err_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/jk_ff_checker.md
# jk_ff_checker

Synthesizable in-circuit checker that sits on the opposite end of a JK flip-flop's stimulus: it observes the J/K inputs and Q/Q_bar outputs of a positive-edge JK flip-flop. It predicts Q from its own JK model and flags every cycle where the flip-flop disagrees. It is the self-checking companion to the JK flip-flop and can sit beside it on silicon or in any bench, replacing visual waveform inspection.

## Interface
- CNT_W, 8, width of the error and check counters; both saturate.
- clk  input  1  clock; rising edge samples all inputs. Same clock as the observed flip-flop.
- rst  input  1  synchronous, active-high reset.
- j  input  1  J input of the observed flip-flop.
- k  input  1  K input of the observed flip-flop.
- q  input  1  Q output of the observed flip-flop.
- q_bar  input  1  Q_bar output of the observed flip-flop.
- synced  output  1  model holds a known Q and compares are active.
- mismatch  output  1  one-cycle pulse on a failed compare.
- fail  output  1  at least one mismatch since reset (sticky).
- err_count  output  CNT_W  failed compares, saturating at all-ones.
- chk_count  output  CNT_W  compares performed, saturating at all-ones.

## Operation
- FSM states: UNSYNC, TRACK, HALT.
- Reset values: state=UNSYNC, model_q=0, synced=0, mismatch=0, fail=0, err_count=0, chk_count=0.
- JK next-state function f(m,j,k): 00 gives m, 01 gives 0, 10 gives 1, 11 gives ~m.
- UNSYNC: the model is unknown, so no compare is performed.
  - On an edge with j^k=1: model_q<=j, go to TRACK.
  - j,k = 00 or 11 stay in UNSYNC.
- TRACK: at each edge the checker performs one compare:
  - Compare q against model_q.
  - Check that q_bar equals ~q.
  - chk_count increments, saturating.
  - The compare fails if either check fails. On failure: mismatch=1, fail<=1, err_count increments (saturating).
  - After the compare, model_q<=f(model_q,j,k).
  - The mismatch path is selected by JK_CHK_STICKY_EN (see Configuration).
- HALT: counters, fail and model are frozen; mismatch=0. Only reset exits HALT.
- Counter saturation: at all-ones the counter holds; no wrap-around.
- X/Z on inputs is not handled; the bench must drive known values.

## Timing
- j,k sampled at edge n; the resulting q is compared at edge n+1 (one-cycle prediction latency).
- The first compare occurs at the edge after the sync edge. synced rises at the sync edge.
- mismatch is registered: asserted for exactly the cycle following the failing edge.
- rst asserted mid-operation: at the next edge all state returns to reset values, including from HALT. Inputs sampled at that edge are ignored; the sync search restarts on the following edge.
- Simultaneous Q mismatch and Q_bar-complement error in one cycle: count once.

## Configuration
- JK_CHK_STICKY_EN defined:
  - First failed compare moves TRACK to HALT.
  - err_count stops at 1.
  - synced stays 1.
- JK_CHK_STICKY_EN undefined:
  - Stay in TRACK.
  - On a mismatch, model_q is realigned to f(q,j,k) using the observed q, so a single flipped state counts exactly once and does not cascade.

## Structure
- Shared package jk_chk_pkg holds:
  - the state enum (UNSYNC, TRACK, HALT);
  - the JK input code constants (HOLD=2'b00, RESET=2'b01, SET=2'b10, TOGGLE=2'b11).
- Sub-module jk_model: pure combinational next-state function f(m,j,k). It is shared with the realign path and reused by future JK-based counters.

## Test plan
- Reset then jk=00,11,01: no compare during 00 and 11. 01 causes sync with model_q=0, synced=1 at that edge; chk_count=1 one edge later, err_count=0.
- Sequence from a correct JK flip-flop, (00,01,10,11,00,10,01,11) repeated 4 times after sync: err_count=0, fail=0, chk_count equals the number of post-sync edges.
- Force q to 1 for one cycle where the model predicts 0, with macro undefined: mismatch pulses once, err_count=1, later compares pass after realign.
- Same fault with JK_CHK_STICKY_EN defined: state HALT, err_count=1, chk_count frozen, fail=1 until rst.
- Drive q_bar equal to q while q matches the model: mismatch=1, err_count increments by exactly 1.
- CNT_W=2, inject 5 faults: err_count holds at 3. Then assert rst mid-stream: all outputs return to 0 and synced=0.
